// File: rtl/mm_control_param_if.sv
// Handshake and address bundle between the matmul sequencer and
// the X/A/P memories plus the MAC datapath.
interface mm_control_param_if #(
    parameter int AXW = 5,
    parameter int AAW = 5,
    parameter int APW = 4
) ();
    logic           Start;
    logic           transpose;
    logic           stall;
    logic           busy;
    logic           done;
    logic           mac_en;
    logic           acc_clr;
    logic           result_en;
    logic [AXW-1:0] addr_x;
    logic [AAW-1:0] addr_A;
    logic [APW-1:0] addr_P;

    modport master (
        input  Start, transpose, stall,
        output busy, done, mac_en, acc_clr, result_en,
        output addr_x, addr_A, addr_P
    );

    modport slave (
        output Start, transpose, stall,
        input  busy, done, mac_en, acc_clr, result_en,
        input  addr_x, addr_A, addr_P
    );
endinterface

// File: rtl/mm_control_param.sv
// Address/sequence controller for an M x K by K x N matrix multiply:
// K MAC cycles per output element followed by one write-back pulse.
module mm_control_param #(
    parameter int M_ROWS  = 4,
    parameter int K_INNER = 6,
    parameter int N_COLS  = 4,
    parameter int AXW     = 5,
    parameter int AAW     = 5,
    parameter int APW     = 4
) (
    input  logic               clk,
    input  logic               rst,
    mm_control_param_if.master bus
);
    localparam int IW = (M_ROWS  > 1) ? $clog2(M_ROWS)  : 1;
    localparam int KW = (K_INNER > 1) ? $clog2(K_INNER) : 1;
    localparam int JW = (N_COLS  > 1) ? $clog2(N_COLS)  : 1;

    localparam logic [2:0] S_IDLE = 3'b000;
    localparam logic [2:0] S_MAC  = 3'b001;
    localparam logic [2:0] S_WB   = 3'b010;
    localparam logic [2:0] S_DONE = 3'b100;

    if ((M_ROWS < 1) || (K_INNER < 1) || (N_COLS < 1)) begin : g_dim_chk
        $error("mm_control_param: dimensions must be >= 1");
    end
    if ((1 << AXW) < M_ROWS * K_INNER) begin : g_axw_chk
        $error("mm_control_param: AXW too narrow");
    end
    if ((1 << AAW) < K_INNER * N_COLS) begin : g_aaw_chk
        $error("mm_control_param: AAW too narrow");
    end
    if ((1 << APW) < M_ROWS * N_COLS) begin : g_apw_chk
        $error("mm_control_param: APW too narrow");
    end

    logic [2:0]    state;
    logic [IW-1:0] i;
    logic [JW-1:0] j;
    logic [KW-1:0] k;
    logic          tmode;

    logic in_mac, in_wb, in_done;
    logic last_i, last_j, last_k;

    assign in_mac  = (state == S_MAC);
    assign in_wb   = (state == S_WB);
    assign in_done = (state == S_DONE);

    assign last_i = (i == IW'(M_ROWS - 1));
    assign last_j = (j == JW'(N_COLS - 1));
    assign last_k = (k == KW'(K_INNER - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            tmode <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.Start) begin
                        state <= S_MAC;
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        tmode <= bus.transpose;
                    end
                end
                S_MAC: begin
                    if (!bus.stall) begin
                        if (last_k) begin
                            k     <= '0;
                            state <= S_WB;
                        end else begin
                            k <= k + KW'(1);
                        end
                    end
                end
                S_WB: begin
                    if (!bus.stall) begin
                        if (!last_j) begin
                            j     <= j + JW'(1);
                            state <= S_MAC;
                        end else if (!last_i) begin
                            j     <= '0;
                            i     <= i + IW'(1);
                            state <= S_MAC;
                        end else begin
                            // Leave the counters clean for the next run
                            j     <= '0;
                            i     <= '0;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = in_mac | in_wb | in_done;
    assign bus.done      = in_done;
    assign bus.mac_en    = in_mac & ~bus.stall;
    assign bus.acc_clr   = in_mac & ~bus.stall & (k == '0);
    assign bus.result_en = in_wb & ~bus.stall;

    // Addresses come from registered counters only; stall never reaches them.
    assign bus.addr_x = in_mac
        ? AXW'(32'(i) * 32'(K_INNER) + 32'(k))
        : '0;

    assign bus.addr_A = !in_mac ? '0
        : tmode ? AAW'(32'(j) * 32'(K_INNER) + 32'(k))
        :         AAW'(32'(k) * 32'(N_COLS) + 32'(j));

    assign bus.addr_P = (in_mac | in_wb)
        ? APW'(32'(i) * 32'(N_COLS) + 32'(j))
        : '0;
endmodule

// File: tb/tb_mm_control_param.sv
// Scoreboard bench for mm_control_param: a cycle plan built from the
// matrix-walk formulas drives the inputs and holds the expected outputs.
module tb_mm_control_param;
    logic clk;
    logic rst;

    typedef struct {
        bit start;
        bit tr;
        bit stall;
        bit rst;
        bit busy;
        bit done;
        bit mac;
        bit clr;
        bit res;
        bit ca;
        bit cp;
        int ax;
        int aa;
        int ap;
    } ent_t;

    ent_t plan[$];
    ent_t q0[$];
    ent_t q1[$];

    int checks;
    int failures;
    int c0;
    int c1;

    mm_control_param_if #(.AXW(5), .AAW(5), .APW(4)) b0 ();
    mm_control_param_if #(.AXW(3), .AAW(3), .APW(3)) b1 ();

    mm_control_param #(
        .M_ROWS(4), .K_INNER(6), .N_COLS(4),
        .AXW(5), .AAW(5), .APW(4)
    ) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(b0)
    );

    mm_control_param #(
        .M_ROWS(2), .K_INNER(1), .N_COLS(3),
        .AXW(3), .AAW(3), .APW(3)
    ) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard consumer: one entry per cycle, compared mid-cycle
    ent_t me;
    logic [4:0] of;
    logic [4:0] ef;
    always @(negedge clk) begin
        if (q0.size() > 0) begin
            me = q0.pop_front();
            of = {b0.busy, b0.done, b0.mac_en, b0.acc_clr, b0.result_en};
            ef = {me.busy, me.done, me.mac, me.clr, me.res};
            checks++;
            if (of !== ef
                || (me.ca && (int'(b0.addr_x) !== me.ax
                              || int'(b0.addr_A) !== me.aa))
                || (me.cp && int'(b0.addr_P) !== me.ap)) begin
                failures++;
                $display("FAIL dut0_cyc%0d flags got=%b exp=%b x=%0d/%0d A=%0d/%0d P=%0d/%0d",
                         c0, of, ef, b0.addr_x, me.ax,
                         b0.addr_A, me.aa, b0.addr_P, me.ap);
            end
            c0++;
        end
        if (q1.size() > 0) begin
            me = q1.pop_front();
            of = {b1.busy, b1.done, b1.mac_en, b1.acc_clr, b1.result_en};
            ef = {me.busy, me.done, me.mac, me.clr, me.res};
            checks++;
            if (of !== ef
                || (me.ca && (int'(b1.addr_x) !== me.ax
                              || int'(b1.addr_A) !== me.aa))
                || (me.cp && int'(b1.addr_P) !== me.ap)) begin
                failures++;
                $display("FAIL dut1_cyc%0d flags got=%b exp=%b x=%0d/%0d A=%0d/%0d P=%0d/%0d",
                         c1, of, ef, b1.addr_x, me.ax,
                         b1.addr_A, me.aa, b1.addr_P, me.ap);
            end
            c1++;
        end
    end

    task automatic idle(int cnt);
        ent_t e;
        e = '{default: 0};
        e.ca = 1'b1;
        e.cp = 1'b1;
        repeat (cnt) plan.push_back(e);
    endtask

    // Cycle 0 carries Start; then the i/j/k walk, optional stalls, DONE.
    task automatic gen(int m, int kd, int n, bit tr, bit hold,
                       int si, int sj, int sk, int slen, int wblen);
        ent_t e;
        e = '{default: 0};
        e.start = 1'b1;
        e.tr = tr;
        e.ca = 1'b1;
        e.cp = 1'b1;
        plan.push_back(e);
        for (int i = 0; i < m; i++) begin
            for (int j = 0; j < n; j++) begin
                for (int kk = 0; kk < kd; kk++) begin
                    e = '{default: 0};
                    e.start = hold;
                    e.tr = !tr;
                    e.busy = 1'b1;
                    e.ca = 1'b1;
                    e.cp = 1'b1;
                    e.ax = i * kd + kk;
                    e.aa = tr ? j * kd + kk : kk * n + j;
                    e.ap = i * n + j;
                    if (i == si && j == sj && kk == sk) begin
                        e.stall = 1'b1;
                        repeat (slen) plan.push_back(e);
                    end
                    e.stall = 1'b0;
                    e.mac = 1'b1;
                    e.clr = (kk == 0);
                    plan.push_back(e);
                end
                e = '{default: 0};
                e.start = hold;
                e.tr = !tr;
                e.busy = 1'b1;
                e.cp = 1'b1;
                e.ap = i * n + j;
                if (i == si && j == sj) begin
                    e.stall = 1'b1;
                    repeat (wblen) plan.push_back(e);
                end
                e.stall = 1'b0;
                e.res = 1'b1;
                plan.push_back(e);
            end
        end
        e = '{default: 0};
        e.start = hold;
        e.tr = !tr;
        e.busy = 1'b1;
        e.done = 1'b1;
        plan.push_back(e);
    endtask

    task automatic drive(int d);
        foreach (plan[n]) begin
            rst = plan[n].rst;
            if (d == 0) begin
                b0.Start = plan[n].start;
                b0.transpose = plan[n].tr;
                b0.stall = plan[n].stall;
                q0.push_back(plan[n]);
            end else begin
                b1.Start = plan[n].start;
                b1.transpose = plan[n].tr;
                b1.stall = plan[n].stall;
                q1.push_back(plan[n]);
            end
            @(posedge clk);
            #1;
        end
        plan.delete();
        rst = 1'b0;
        b0.Start = 1'b0;
        b0.stall = 1'b0;
        b1.Start = 1'b0;
        b1.stall = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b0.Start = 1'b1;
        b1.Start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({b0.busy, b0.done, b0.mac_en, b0.acc_clr, b0.result_en,
             b0.addr_x, b0.addr_A, b0.addr_P} !== 19'd0) begin
            failures++;
            $display("FAIL reset_dut0 busy=%b done=%b mac=%b x=%0d A=%0d P=%0d exp all 0",
                     b0.busy, b0.done, b0.mac_en,
                     b0.addr_x, b0.addr_A, b0.addr_P);
        end
        checks++;
        if ({b1.busy, b1.done, b1.mac_en, b1.acc_clr, b1.result_en,
             b1.addr_x, b1.addr_A, b1.addr_P} !== 14'd0) begin
            failures++;
            $display("FAIL reset_dut1 busy=%b done=%b mac=%b x=%0d A=%0d P=%0d exp all 0",
                     b1.busy, b1.done, b1.mac_en,
                     b1.addr_x, b1.addr_A, b1.addr_P);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        b0.Start = 1'b0;
        b1.Start = 1'b0;
    endtask

    task automatic test_basic();
        gen(4, 6, 4, 1'b0, 1'b0, -1, -1, -1, 0, 0);
        idle(2);
        drive(0);
    endtask

    task automatic test_transpose();
        gen(4, 6, 4, 1'b1, 1'b0, -1, -1, -1, 0, 0);
        idle(2);
        drive(0);
    endtask

    task automatic test_stall();
        gen(4, 6, 4, 1'b0, 1'b0, 1, 2, 3, 2, 2);
        idle(2);
        drive(0);
    endtask

    task automatic test_start_busy();
        gen(4, 6, 4, 1'b0, 1'b0, -1, -1, -1, 0, 0);
        plan[20].start = 1'b1;
        plan[plan.size() - 1].start = 1'b1;
        idle(3);
        drive(0);
    endtask

    task automatic test_back_to_back();
        gen(4, 6, 4, 1'b0, 1'b1, -1, -1, -1, 0, 0);
        gen(4, 6, 4, 1'b1, 1'b0, -1, -1, -1, 0, 0);
        idle(2);
        drive(0);
    endtask

    task automatic test_mid_reset();
        gen(4, 6, 4, 1'b0, 1'b0, -1, -1, -1, 0, 0);
        while (plan.size() > 51) plan.pop_back();
        plan[50].rst = 1'b1;
        idle(1);
        gen(4, 6, 4, 1'b0, 1'b0, -1, -1, -1, 0, 0);
        idle(2);
        drive(0);
    endtask

    task automatic test_k1();
        gen(2, 1, 3, 1'b0, 1'b0, -1, -1, -1, 0, 0);
        idle(2);
        gen(2, 1, 3, 1'b1, 1'b0, 0, 1, 0, 1, 3);
        idle(2);
        drive(1);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        c0 = 0;
        c1 = 0;
        rst = 1'b1;
        b0.Start = 1'b0;
        b0.transpose = 1'b0;
        b0.stall = 1'b0;
        b1.Start = 1'b0;
        b1.transpose = 1'b0;
        b1.stall = 1'b0;
        test_reset();
        test_basic();
        test_transpose();
        test_stall();
        test_start_busy();
        test_back_to_back();
        test_mid_reset();
        test_k1();
        @(posedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL drain q0=%0d q1=%0d exp 0", q0.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
